vending_ctrl_multi: RTL and testbench
=====================================

// Module: vending_ctrl_multi
// PURPOSE
//   Parametrised vending controller. Accumulates coin credit, vends one of NUM_PRODUCTS
//   items at runtime-programmable prices, then returns change one unit per cycle.
//   Adds what the fixed 3-product controller lacked: a real credit register, price check,
//   sold-out, cancel/refund, overflow reject. Sits between coin acceptor and dispenser/hopper.
// PARAMETERS
//   NUM_PRODUCTS  3    number of products / select lines (1..16)
//   CREDIT_W      8    width of credit, price and coin arithmetic (unsigned)
//   COIN_A        5    value credited by one coin_a pulse
//   COIN_B        10   value credited by one coin_b pulse
//   CHANGE_UNIT   5    value of one change_pulse; COIN_A, COIN_B, prices must be multiples
//   MAX_CREDIT    200  max credit held; must be <= 2**CREDIT_W-1
// PORTS
//   clk           in   1                       rising-edge clock
//   reset         in   1                       synchronous, active-high reset
//   coin_a        in   1                       1-cycle pulse: coin of value COIN_A inserted
//   coin_b        in   1                       1-cycle pulse: coin of value COIN_B inserted
//   select        in   NUM_PRODUCTS            product request, sampled per cycle
//   cancel        in   1                       refund all credit
//   price         in   NUM_PRODUCTS*CREDIT_W   flat price table, product i at [i*CREDIT_W +: CREDIT_W]
//   sold_out      in   NUM_PRODUCTS            1 = product i cannot be vended
//   credit        out  CREDIT_W                current credit (registered)
//   dispense      out  1                       1-cycle pulse: vend product dispense_id
//   dispense_id   out  $clog2(NUM_PRODUCTS)+1  index of vended product, valid with dispense
//   change_pulse  out  1                       1 cycle per CHANGE_UNIT returned
//   coin_reject   out  1                       1-cycle pulse: coin not credited, return it
//   vend_err      out  1                       1-cycle pulse: insufficient credit or sold out
//   busy          out  1                       1 in VEND or CHANGE
// BEHAVIOUR
//   Reset: state=IDLE, credit=0, all outputs 0. Applies in any state; change in flight is dropped.
//   All outputs registered. Input at edge N gives response in cycle N+1.
//   States: IDLE(credit==0), CREDIT, VEND, CHANGE.
//   IDLE/CREDIT, per-cycle priority: cancel > select > coin.
//     coin: credit+value computed at CREDIT_W+1 bits. If <= MAX_CREDIT, credit updates and
//       state=CREDIT. Else coin_reject=1, credit unchanged.
//     coin_a & coin_b same cycle: credit COIN_A+COIN_B if it fits, else reject both (one pulse).
//     coin in same cycle as a winning cancel/select: coin_reject=1, not credited.
//     select: lowest set bit i wins. If sold_out[i] or credit < price[i]: vend_err=1,
//       state/credit unchanged. Else next state VEND.
//     cancel with credit==0: ignored. Otherwise next state CHANGE.
//   VEND (1 cycle): dispense=1, dispense_id=i, credit <= credit-price[i].
//     Next: CHANGE if remainder >= CHANGE_UNIT, else IDLE with credit forced to 0.
//   CHANGE: each cycle change_pulse=1, credit -= CHANGE_UNIT. Return to IDLE with
//     credit=0 on the cycle after the last pulse. A residue < CHANGE_UNIT is cleared.
//   VEND/CHANGE: every coin gives coin_reject; select and cancel are ignored.
//   price[i]==0 is legal: vends with any credit, including 0 from IDLE.
//   Dispense order: dispense always precedes that transaction's first change_pulse.
//     Total change pulses = (credit - price) / CHANGE_UNIT.
// TESTING
//   1. coin_b,coin_b,coin_a (25); select=001, price0=15 -> dispense id0 next cycle,
//      then exactly 2 change_pulse, credit 25->10->5->0, IDLE.
//   2. credit 10, select product price 15 -> vend_err 1 cycle, credit stays 10, no dispense.
//   3. credit 195, MAX_CREDIT 200: coin_b -> coin_reject, credit 195. coin_a -> credit 200.
//   4. credit 30, cancel and select and coin_a same cycle -> coin_reject,
//      6 change_pulse, no dispense.
//   5. credit 20, select=110 -> product 1 chosen. sold_out[1]=1 -> vend_err.
//   6. reset asserted mid-CHANGE after 1 of 4 pulses -> next cycle all outputs 0,
//      credit 0, IDLE, no further pulses.

Source files
------------

// File: rtl/vending_ctrl_multi_if.sv
// Purpose: bundles the vending controller's coin-acceptor, selector and
//          dispenser/hopper signals into one interface.
// Signals:
//   coin_a, coin_b, cancel   master -> slave  single-cycle request pulses
//   select, sold_out         master -> slave  per-product request / availability
//   price                    master -> slave  flat price table, product i at [i*CREDIT_W +: CREDIT_W]
//   credit                   slave -> master  current credit
//   dispense, dispense_id    slave -> master  vend pulse and product index
//   change_pulse             slave -> master  one pulse per change unit returned
//   coin_reject, vend_err    slave -> master  reject / error pulses
//   busy                     slave -> master  vending or returning change
interface vending_ctrl_multi_if #(
  parameter int NUM_PRODUCTS = 3,
  parameter int CREDIT_W     = 8,
  parameter int ID_W         = $clog2(NUM_PRODUCTS) + 1
);
  logic                             coin_a;
  logic                             coin_b;
  logic                             cancel;
  logic [NUM_PRODUCTS-1:0]          select;
  logic [NUM_PRODUCTS-1:0]          sold_out;
  logic [NUM_PRODUCTS*CREDIT_W-1:0] price;
  logic [CREDIT_W-1:0]              credit;
  logic                             dispense;
  logic [ID_W-1:0]                  dispense_id;
  logic                             change_pulse;
  logic                             coin_reject;
  logic                             vend_err;
  logic                             busy;

  modport master (
    output coin_a, coin_b, cancel, select, sold_out, price,
    input  credit, dispense, dispense_id, change_pulse, coin_reject, vend_err, busy
  );

  modport slave (
    input  coin_a, coin_b, cancel, select, sold_out, price,
    output credit, dispense, dispense_id, change_pulse, coin_reject, vend_err, busy
  );
endinterface

// File: rtl/vending_ctrl_multi.sv
// Purpose: parametrised vending controller. Accumulates coin credit, vends one
//          of NUM_PRODUCTS items at runtime prices, then pays change back one
//          CHANGE_UNIT per cycle. Supports sold-out, cancel/refund and
//          over-credit coin rejection. All outputs are registered.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    vending_ctrl_multi_if.slave (coin/select/cancel/price/sold_out in,
//          credit/dispense/dispense_id/change_pulse/coin_reject/vend_err/busy out)

// Per-product purchase check: can product be vended with the current credit.
module vending_slot #(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] price_i,
  input  logic [CREDIT_W-1:0] credit_i,
  input  logic                sold_out_i,
  output logic                ok_o
);
  assign ok_o = !sold_out_i && (credit_i >= price_i);
endmodule

module vending_ctrl_multi #(
  parameter int NUM_PRODUCTS = 3,
  parameter int CREDIT_W     = 8,
  parameter int COIN_A       = 5,
  parameter int COIN_B       = 10,
  parameter int CHANGE_UNIT  = 5,
  parameter int MAX_CREDIT   = 200
) (
  input  logic                 clk,
  input  logic                 reset,
  vending_ctrl_multi_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_PRODUCTS) + 1;
  // Two extra bits so credit + COIN_A + COIN_B can never wrap.
  localparam int SW   = CREDIT_W + 2;

  localparam logic [CREDIT_W-1:0] UNIT  = CREDIT_W'(CHANGE_UNIT);
  localparam logic [SW-1:0]       VAL_A = SW'(COIN_A);
  localparam logic [SW-1:0]       VAL_B = SW'(COIN_B);
  localparam logic [SW-1:0]       MAX_S = SW'(MAX_CREDIT);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                dispense_q, dispense_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                pulse_q, pulse_d;
  logic                rej_q, rej_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic [NUM_PRODUCTS-1:0][CREDIT_W-1:0] price_arr;
  logic [NUM_PRODUCTS-1:0]               ok;

  assign price_arr = bus.price;

  generate
    for (genvar g = 0; g < NUM_PRODUCTS; g++) begin : g_slot
      vending_slot #(.CREDIT_W(CREDIT_W)) u_slot (
        .price_i    (price_arr[g]),
        .credit_i   (credit_q),
        .sold_out_i (bus.sold_out[g]),
        .ok_o       (ok[g])
      );
    end
  endgenerate

  // Lowest set select bit wins: scan high->low so the lowest index lands last.
  logic                sel_any;
  logic                sel_ok;
  logic [ID_W-1:0]     sel_idx;
  logic [CREDIT_W-1:0] sel_price;

  always_comb begin
    sel_any   = |bus.select;
    sel_ok    = 1'b0;
    sel_idx   = '0;
    sel_price = '0;
    for (int i = NUM_PRODUCTS - 1; i >= 0; i--) begin
      if (bus.select[i]) begin
        sel_ok    = ok[i];
        sel_idx   = ID_W'(i);
        sel_price = price_arr[i];
      end
    end
  end

  // Both coins in one cycle are credited (or rejected) together.
  logic          coin_any;
  logic [SW-1:0] coin_val;
  logic [SW-1:0] coin_sum;

  assign coin_any = bus.coin_a | bus.coin_b;
  assign coin_val = (bus.coin_a ? VAL_A : '0) + (bus.coin_b ? VAL_B : '0);
  assign coin_sum = {2'b00, credit_q} + coin_val;

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    dispense_d = 1'b0;
    id_d       = '0;
    pulse_d    = 1'b0;
    rej_d      = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE, CREDIT: begin
        if (bus.cancel && (credit_q != '0)) begin
          rej_d = coin_any;
          // Entering CHANGE pays the first unit at once; a sub-unit residue is just cleared.
          if (credit_q >= UNIT) begin
            state_d  = CHANGE;
            pulse_d  = 1'b1;
            credit_d = credit_q - UNIT;
          end else begin
            state_d  = IDLE;
            credit_d = '0;
          end
        end else if (sel_any) begin
          // A select consumes the cycle even when it fails, so any coin is bounced.
          rej_d = coin_any;
          if (sel_ok) begin
            state_d    = VEND;
            dispense_d = 1'b1;
            id_d       = sel_idx;
            credit_d   = credit_q - sel_price;
          end else begin
            err_d = 1'b1;
          end
        end else if (coin_any) begin
          if (coin_sum <= MAX_S) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = CREDIT;
          end else begin
            rej_d = 1'b1;
          end
        end
      end

      // Credit already holds the remainder; pay it out unit by unit, and leave
      // for IDLE on the cycle after the last unit.
      VEND, CHANGE: begin
        rej_d = coin_any;
        if (credit_q >= UNIT) begin
          state_d  = CHANGE;
          pulse_d  = 1'b1;
          credit_d = credit_q - UNIT;
        end else begin
          state_d  = IDLE;
          credit_d = '0;
        end
      end

      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase

    busy_d = (state_d == VEND) || (state_d == CHANGE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      dispense_q <= 1'b0;
      id_q       <= '0;
      pulse_q    <= 1'b0;
      rej_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      dispense_q <= dispense_d;
      id_q       <= id_d;
      pulse_q    <= pulse_d;
      rej_q      <= rej_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.credit       = credit_q;
  assign bus.dispense     = dispense_q;
  assign bus.dispense_id  = id_q;
  assign bus.change_pulse = pulse_q;
  assign bus.coin_reject  = rej_q;
  assign bus.vend_err     = err_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_vending_ctrl_multi.sv
// Directed bench for vending_ctrl_multi: a table of per-cycle vectors with
// hand-computed outputs, plus hand-written sequences for the overflow limit
// and reset in the middle of a change payout.
module tb_vending_ctrl_multi;
  localparam int NP  = 3;
  localparam int CW  = 8;
  localparam int IDW = $clog2(NP) + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vending_ctrl_multi_if #(.NUM_PRODUCTS(NP), .CREDIT_W(CW)) bus ();

  vending_ctrl_multi #(
    .NUM_PRODUCTS(NP), .CREDIT_W(CW), .COIN_A(5), .COIN_B(10),
    .CHANGE_UNIT(5), .MAX_CREDIT(200)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [CW-1:0]  credit;
    logic           disp;
    logic [IDW-1:0] id;
    logic           pulse;
    logic           rej;
    logic           err;
    logic           busy;
  } out_t;

  typedef struct {
    logic          ca, cb, cn;
    logic [NP-1:0] sel, so;
    out_t          exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic out_t mk(int credit, bit disp, int id, bit pulse, bit rej, bit err, bit busy);
    out_t o;
    o.credit = CW'(credit);
    o.disp   = disp;
    o.id     = IDW'(id);
    o.pulse  = pulse;
    o.rej    = rej;
    o.err    = err;
    o.busy   = busy;
    return o;
  endfunction

  task automatic add(bit ca, bit cb, bit cn, logic [NP-1:0] sel, logic [NP-1:0] so, out_t exp);
    vec_t v;
    v.ca = ca; v.cb = cb; v.cn = cn; v.sel = sel; v.so = so; v.exp = exp;
    vecs.push_back(v);
  endtask

  function automatic out_t sample();
    out_t o;
    o.credit = bus.credit;
    o.disp   = bus.dispense;
    o.id     = bus.dispense_id;
    o.pulse  = bus.change_pulse;
    o.rej    = bus.coin_reject;
    o.err    = bus.vend_err;
    o.busy   = bus.busy;
    return o;
  endfunction

  task automatic check(string name, out_t exp);
    out_t got;
    got = sample();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got credit=%0d disp=%0b id=%0d pulse=%0b rej=%0b err=%0b busy=%0b, expected credit=%0d disp=%0b id=%0d pulse=%0b rej=%0b err=%0b busy=%0b",
               name, got.credit, got.disp, got.id, got.pulse, got.rej, got.err, got.busy,
               exp.credit, exp.disp, exp.id, exp.pulse, exp.rej, exp.err, exp.busy);
    end
  endtask

  // Drive one cycle of inputs, let the edge capture them, sample just after.
  task automatic step(bit ca, bit cb, bit cn, logic [NP-1:0] sel, logic [NP-1:0] so);
    @(negedge clk);
    bus.coin_a   = ca;
    bus.coin_b   = cb;
    bus.cancel   = cn;
    bus.select   = sel;
    bus.sold_out = so;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(string name);
    @(negedge clk);
    reset        = 1'b1;
    bus.coin_a   = 1'b0;
    bus.coin_b   = 1'b0;
    bus.cancel   = 1'b0;
    bus.select   = '0;
    bus.sold_out = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check(name, mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // product2 = 0, product1 = 10, product0 = 15
    bus.price = {8'd0, 8'd10, 8'd15};
    reset     = 1'b1;

    //    ca cb cn sel     so        credit disp id pulse rej err busy
    // buy product0 (15) with 25: dispense, then two change pulses
    add(0, 1, 0, 3'b000, 3'b000, mk(10, 0, 0, 0, 0, 0, 0));
    add(0, 1, 0, 3'b000, 3'b000, mk(20, 0, 0, 0, 0, 0, 0));
    add(1, 0, 0, 3'b000, 3'b000, mk(25, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 3'b001, 3'b000, mk(10, 1, 0, 0, 0, 0, 1));
    add(0, 0, 0, 3'b000, 3'b000, mk( 5, 0, 0, 1, 0, 0, 1));
    add(0, 0, 0, 3'b000, 3'b000, mk( 0, 0, 0, 1, 0, 0, 1));
    add(0, 0, 0, 3'b000, 3'b000, mk( 0, 0, 0, 0, 0, 0, 0));
    // insufficient credit: 10 < 15
    add(0, 1, 0, 3'b000, 3'b000, mk(10, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 3'b001, 3'b000, mk(10, 0, 0, 0, 0, 1, 0));
    add(0, 0, 0, 3'b000, 3'b000, mk(10, 0, 0, 0, 0, 0, 0));
    // select=110 picks product1; sold out first, then available
    add(0, 1, 0, 3'b000, 3'b000, mk(20, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 3'b110, 3'b010, mk(20, 0, 0, 0, 0, 1, 0));
    add(0, 0, 0, 3'b110, 3'b000, mk(10, 1, 1, 0, 0, 0, 1));
    // coin while busy is rejected; select/cancel while busy ignored
    add(1, 0, 0, 3'b000, 3'b000, mk( 5, 0, 0, 1, 1, 0, 1));
    add(0, 0, 1, 3'b001, 3'b000, mk( 0, 0, 0, 1, 0, 0, 1));
    add(0, 0, 0, 3'b000, 3'b000, mk( 0, 0, 0, 0, 0, 0, 0));
    // zero-price product vends from empty credit, no change
    add(0, 0, 0, 3'b100, 3'b000, mk( 0, 1, 2, 0, 0, 0, 1));
    add(0, 0, 0, 3'b000, 3'b000, mk( 0, 0, 0, 0, 0, 0, 0));
    // cancel with no credit does nothing
    add(0, 0, 1, 3'b000, 3'b000, mk( 0, 0, 0, 0, 0, 0, 0));
    // both coins at once, then cancel beats select and coin: 30 -> 6 pulses
    add(1, 1, 0, 3'b000, 3'b000, mk(15, 0, 0, 0, 0, 0, 0));
    add(1, 1, 0, 3'b000, 3'b000, mk(30, 0, 0, 0, 0, 0, 0));
    add(1, 0, 1, 3'b001, 3'b000, mk(25, 0, 0, 1, 1, 0, 1));
    add(0, 0, 0, 3'b000, 3'b000, mk(20, 0, 0, 1, 0, 0, 1));
    add(0, 0, 0, 3'b000, 3'b000, mk(15, 0, 0, 1, 0, 0, 1));
    add(0, 0, 0, 3'b000, 3'b000, mk(10, 0, 0, 1, 0, 0, 1));
    add(0, 0, 0, 3'b000, 3'b000, mk( 5, 0, 0, 1, 0, 0, 1));
    add(0, 0, 0, 3'b000, 3'b000, mk( 0, 0, 0, 1, 0, 0, 1));
    add(0, 0, 0, 3'b000, 3'b000, mk( 0, 0, 0, 0, 0, 0, 0));

    do_reset("reset_state");

    foreach (vecs[i]) begin
      step(vecs[i].ca, vecs[i].cb, vecs[i].cn, vecs[i].sel, vecs[i].so);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Credit ceiling: build 195, then probe the limit.
    do_reset("reset_before_limit");
    for (int i = 0; i < 19; i++) step(0, 1, 0, '0, '0);
    step(1, 0, 0, '0, '0);
    check("limit_build_195", mk(195, 0, 0, 0, 0, 0, 0));
    step(1, 1, 0, '0, '0);
    check("limit_both_coins_reject", mk(195, 0, 0, 0, 1, 0, 0));
    step(0, 1, 0, '0, '0);
    check("limit_coin_b_reject", mk(195, 0, 0, 0, 1, 0, 0));
    step(1, 0, 0, '0, '0);
    check("limit_coin_a_to_200", mk(200, 0, 0, 0, 0, 0, 0));
    step(1, 0, 0, '0, '0);
    check("limit_full_reject", mk(200, 0, 0, 0, 1, 0, 0));

    // Reset during change payout drops the remaining pulses.
    do_reset("reset_before_midchange");
    step(0, 1, 0, '0, '0);
    step(0, 1, 0, '0, '0);
    check("midchange_credit_20", mk(20, 0, 0, 0, 0, 0, 0));
    step(0, 0, 1, '0, '0);
    check("midchange_first_pulse", mk(15, 0, 0, 1, 0, 0, 1));
    @(negedge clk);
    bus.cancel = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    check("midchange_reset_clears", mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, '0, '0);
      check($sformatf("midchange_quiet%0d", i), mk(0, 0, 0, 0, 0, 0, 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
